// File: rtl/mcif_write_eg_bresp.sv
// MCIF write egress response stage.
// Takes AXI B responses from the NoC, pops the matching per-thread context
// queue entry written by ingress, hands the burst length back to ingress as a
// credit release and pulses write-complete to the owning client when the
// original request asked for an acknowledge.
module mcif_write_eg_bresp (
   input  logic       nvdla_core_clk,
   input  logic       nvdla_core_rst,
   input  logic       noc2mcif_axi_b_bvalid,
   output logic       noc2mcif_axi_b_bready,
   input  logic [7:0] noc2mcif_axi_b_bid,
   input  logic       cq_rd1_pvld,
   output logic       cq_rd1_prdy,
   input  logic [2:0] cq_rd1_pd,
   input  logic       cq_rd2_pvld,
   output logic       cq_rd2_prdy,
   input  logic [2:0] cq_rd2_pd,
   input  logic       cq_rd3_pvld,
   output logic       cq_rd3_prdy,
   input  logic [2:0] cq_rd3_pd,
   output logic       eg2ig_axi_vld,
   output logic [1:0] eg2ig_axi_len,
   output logic       mcif2sdp_wr_rsp_complete,
   output logic       mcif2pdp_wr_rsp_complete,
   output logic       mcif2cdp_wr_rsp_complete,
   output logic       mcif_wr_eg_bad_bid
);

   // Thread IDs carried in bid[3:0]; every other value is illegal.
   localparam logic [3:0] THREAD_SDP = 4'd1;
   localparam logic [3:0] THREAD_PDP = 4'd2;
   localparam logic [3:0] THREAD_CDP = 4'd3;

   // B skid register
   logic       bVld_q;
   logic       bVld_d;
   logic [3:0] bId_q;
   logic [3:0] bId_d;

   // Registered outputs
   logic       egVld_q;
   logic       egVld_d;
   logic [1:0] egLen_q;
   logic [1:0] egLen_d;
   logic       sdpDone_q;
   logic       sdpDone_d;
   logic       pdpDone_q;
   logic       pdpDone_d;
   logic       cdpDone_q;
   logic       cdpDone_d;
   logic       badBid_q;
   logic       badBid_d;

   // Decoded view of the held response
   logic       selLegal;
   logic       selPvld;
   logic [2:0] selPd;
   logic       selRequireAck;
   logic [1:0] selLen;
   logic       pop;
   logic       bad;
   logic       bReady;
   logic       bAccept;

   // Route the context queue head of the thread named by the held ID.
   always_comb begin
      selLegal = 1'b0;
      selPvld  = 1'b0;
      selPd    = 3'b000;
      case (bId_q)
         THREAD_SDP: begin
            selLegal = 1'b1;
            selPvld  = cq_rd1_pvld;
            selPd    = cq_rd1_pd;
         end
         THREAD_PDP: begin
            selLegal = 1'b1;
            selPvld  = cq_rd2_pvld;
            selPd    = cq_rd2_pd;
         end
         THREAD_CDP: begin
            selLegal = 1'b1;
            selPvld  = cq_rd3_pvld;
            selPd    = cq_rd3_pd;
         end
         default: begin
            selLegal = 1'b0;
            selPvld  = 1'b0;
            selPd    = 3'b000;
         end
      endcase
   end

   assign selRequireAck = selPd[2];
   assign selLen        = selPd[1:0];

   // A legal held response retires once its queue head is present; an
   // illegal one is dropped immediately so it cannot wedge the B channel.
   assign pop = bVld_q && selLegal && selPvld;
   assign bad = bVld_q && !selLegal;

   // Ready stays low through reset so nothing is accepted into a register
   // that is being cleared; otherwise the skid slot is free or freeing.
   assign bReady  = !nvdla_core_rst && (!bVld_q || pop || bad);
   assign bAccept = noc2mcif_axi_b_bvalid && bReady;

   assign noc2mcif_axi_b_bready = bReady;

   // Pop strobes follow the held ID even while stalled on an empty queue.
   assign cq_rd1_prdy = bVld_q && (bId_q == THREAD_SDP);
   assign cq_rd2_prdy = bVld_q && (bId_q == THREAD_PDP);
   assign cq_rd3_prdy = bVld_q && (bId_q == THREAD_CDP);

   // Next state of the skid register: a new accept wins over retirement.
   always_comb begin
      bVld_d = bVld_q;
      bId_d  = bId_q;
      if (bAccept) begin
         bVld_d = 1'b1;
         bId_d  = noc2mcif_axi_b_bid[3:0];
      end else if (pop || bad) begin
         bVld_d = 1'b0;
      end
   end

   // Next state of the output pulses, recomputed every cycle so each lasts one cycle.
   always_comb begin
      egVld_d   = pop;
      egLen_d   = pop ? selLen : 2'b00;
      sdpDone_d = pop && selRequireAck && (bId_q == THREAD_SDP);
      pdpDone_d = pop && selRequireAck && (bId_q == THREAD_PDP);
      cdpDone_d = pop && selRequireAck && (bId_q == THREAD_CDP);
      badBid_d  = badBid_q || bad;
   end

   // Hold the accepted B response until its queue entry has been popped.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         bVld_q <= 1'b0;
         bId_q  <= 4'd0;
      end else begin
         bVld_q <= bVld_d;
         bId_q  <= bId_d;
      end
   end

   // Register credit release and client completes so no queue input reaches them combinationally.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         egVld_q   <= 1'b0;
         egLen_q   <= 2'b00;
         sdpDone_q <= 1'b0;
         pdpDone_q <= 1'b0;
         cdpDone_q <= 1'b0;
      end else begin
         egVld_q   <= egVld_d;
         egLen_q   <= egLen_d;
         sdpDone_q <= sdpDone_d;
         pdpDone_q <= pdpDone_d;
         cdpDone_q <= cdpDone_d;
      end
   end

   // Sticky record that the NoC returned an ID no client owns; only reset clears it.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         badBid_q <= 1'b0;
      end else begin
         badBid_q <= badBid_d;
      end
   end

   assign eg2ig_axi_vld            = egVld_q;
   assign eg2ig_axi_len            = egLen_q;
   assign mcif2sdp_wr_rsp_complete = sdpDone_q;
   assign mcif2pdp_wr_rsp_complete = pdpDone_q;
   assign mcif2cdp_wr_rsp_complete = cdpDone_q;
   assign mcif_wr_eg_bad_bid       = badBid_q;

endmodule
